// File: rtl/pipe_ctrl_hazard.sv
// pipe_ctrl_hazard
//   Back end of the ID-stage control decode. Carries the decoded control bundle through
//   ID/EX, EX/MEM and MEM/WB. Detects load-use, branch-operand and (optionally) plain RAW
//   hazards. Drives the stall/noop request and the IF/ID flush. Produces the EX-stage
//   forwarding selects and keeps a saturating count of stall cycles.
//
//   Bundle layout (id_ctrl_i / ex_ctrl_o):
//     [7:6] ALUOp, [5] ALUSrc, [4] branch, [3] MemRead, [2] MemWrite, [1] RegWrite, [0] MemtoReg
//
// Ports
//   clk_i          clock, rising edge
//   rst_n_i        asynchronous active-low reset
//   id_ctrl_i      decoded control bundle in ID
//   id_rs1_i       ID source register 1
//   id_rs2_i       ID source register 2
//   id_rd_i        ID destination register
//   branch_taken_i ID comparator result
//   noop_o         decoder noop request (same as stall_o)
//   stall_o        hold PC and IF/ID this cycle
//   flush_o        clear IF/ID at the next edge
//   ex_ctrl_o      ID/EX bundle
//   ex_rd_o        ID/EX destination register
//   mem_ctrl_o     EX/MEM {MemRead, MemWrite, RegWrite, MemtoReg}
//   mem_rd_o       EX/MEM destination register
//   wb_ctrl_o      MEM/WB {RegWrite, MemtoReg}
//   wb_rd_o        MEM/WB destination register
//   fwd_a_o        EX operand A select: 00 regfile, 10 EX/MEM, 01 MEM/WB
//   fwd_b_o        EX operand B select, same encoding
//   stall_cnt_o    stall cycles since reset, saturating
module pipe_ctrl_hazard #(
  parameter int unsigned RA_W   = 5,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [7:0]       id_ctrl_i,
  input  logic [RA_W-1:0]  id_rs1_i,
  input  logic [RA_W-1:0]  id_rs2_i,
  input  logic [RA_W-1:0]  id_rd_i,
  input  logic             branch_taken_i,
  output logic             noop_o,
  output logic             stall_o,
  output logic             flush_o,
  output logic [7:0]       ex_ctrl_o,
  output logic [RA_W-1:0]  ex_rd_o,
  output logic [3:0]       mem_ctrl_o,
  output logic [RA_W-1:0]  mem_rd_o,
  output logic [1:0]       wb_ctrl_o,
  output logic [RA_W-1:0]  wb_rd_o,
  output logic [1:0]       fwd_a_o,
  output logic [1:0]       fwd_b_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  // Stage registers
  logic [7:0]       ex_ctrl_q, ex_ctrl_d;
  logic [RA_W-1:0]  ex_rd_q, ex_rd_d;
  logic [RA_W-1:0]  ex_rs1_q, ex_rs1_d;
  logic [RA_W-1:0]  ex_rs2_q, ex_rs2_d;
  logic [3:0]       mem_ctrl_q;
  logic [RA_W-1:0]  mem_rd_q;
  logic [1:0]       wb_ctrl_q;
  logic [RA_W-1:0]  wb_rd_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_match, mem_match;
  logic load_use, branch_haz, nofwd_haz;
  logic stall;

  // rd=0 is the hardwired zero register and never creates a dependency.
  function automatic logic rd_match(input logic [RA_W-1:0] rd,
                                    input logic [RA_W-1:0] rs1,
                                    input logic [RA_W-1:0] rs2);
    return (rd != '0) && ((rd == rs1) || (rd == rs2));
  endfunction

  always_comb begin
    ex_match   = rd_match(ex_rd_q, id_rs1_i, id_rs2_i);
    mem_match  = rd_match(mem_rd_q, id_rs1_i, id_rs2_i);
    load_use   = ex_ctrl_q[3] & ex_match;
    // Branches resolve in ID, so EX results and MEM loads cannot be forwarded in time.
    branch_haz = id_ctrl_i[4] & ((ex_ctrl_q[1] & ex_match) | (mem_ctrl_q[3] & mem_match));
    nofwd_haz  = 1'b0;
    if (FWD_EN == 0) begin
      // WB-stage writes are covered by the write-first register file.
      nofwd_haz = (ex_ctrl_q[1] & ex_match) | (mem_ctrl_q[1] & mem_match);
    end
    stall = load_use | branch_haz | nofwd_haz;
  end

  // ID/EX next state: a stall injects an all-zero bubble.
  always_comb begin
    ex_ctrl_d = id_ctrl_i;
    ex_rd_d   = id_rd_i;
    ex_rs1_d  = id_rs1_i;
    ex_rs2_d  = id_rs2_i;
    if (stall) begin
      ex_ctrl_d = '0;
      ex_rd_d   = '0;
      ex_rs1_d  = '0;
      ex_rs2_d  = '0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ex_ctrl_q  <= '0;
      ex_rd_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      mem_ctrl_q <= '0;
      mem_rd_q   <= '0;
      wb_ctrl_q  <= '0;
      wb_rd_q    <= '0;
      cnt_q      <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      mem_ctrl_q <= ex_ctrl_q[3:0];
      mem_rd_q   <= ex_rd_q;
      wb_ctrl_q  <= mem_ctrl_q[1:0];
      wb_rd_q    <= mem_rd_q;
      cnt_q      <= cnt_d;
    end
  end

  // Forwarding selects; EX/MEM takes priority as the younger result.
  if (FWD_EN != 0) begin : g_fwd
    always_comb begin
      fwd_a_o = 2'b00;
      fwd_b_o = 2'b00;
      if (mem_ctrl_q[1] && (mem_rd_q != '0) && (mem_rd_q == ex_rs1_q)) begin
        fwd_a_o = 2'b10;
      end else if (wb_ctrl_q[1] && (wb_rd_q != '0) && (wb_rd_q == ex_rs1_q)) begin
        fwd_a_o = 2'b01;
      end
      if (mem_ctrl_q[1] && (mem_rd_q != '0) && (mem_rd_q == ex_rs2_q)) begin
        fwd_b_o = 2'b10;
      end else if (wb_ctrl_q[1] && (wb_rd_q != '0) && (wb_rd_q == ex_rs2_q)) begin
        fwd_b_o = 2'b01;
      end
    end
  end else begin : g_nofwd
    assign fwd_a_o = 2'b00;
    assign fwd_b_o = 2'b00;
  end

  assign stall_o     = stall;
  assign noop_o      = stall;
  assign flush_o     = id_ctrl_i[4] & branch_taken_i & ~stall;
  assign ex_ctrl_o   = ex_ctrl_q;
  assign ex_rd_o     = ex_rd_q;
  assign mem_ctrl_o  = mem_ctrl_q;
  assign mem_rd_o    = mem_rd_q;
  assign wb_ctrl_o   = wb_ctrl_q;
  assign wb_rd_o     = wb_rd_q;
  assign stall_cnt_o = cnt_q;

endmodule
